dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter INDEX_W, default 9: set-index width. The line count is 2^INDEX_W. The tag is cpu_addr[31:5+INDEX_W]. Only 9 is supported with the 19-bit refill tag port.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cpu_rd_req  in  1  load request from the MEM stage.
REQ-005 cpu_wr_req  in  1  store request from the MEM stage.
REQ-006 cpu_addr  in  32  byte address; word-aligned, bits [1:0] are ignored.
REQ-007 cpu_wr_data  in  32  store data.
REQ-008 cpu_rd_data  out  32  load data; combinational on a hit.
REQ-009 cpu_stall  out  1  pipeline freeze; the CPU holds its request stable while this is high.
REQ-010 rd_miss  out  1  load-miss request to the miss handler.
REQ-011 wr_miss  out  1  store-miss request to the miss handler.
REQ-012 miss_addr  out  32  latched miss address.
REQ-013 wr_miss_data  out  32  latched store data for the miss handler to merge.
REQ-014 upd_entry  in  1  one-cycle refill-complete pulse from the miss handler.
REQ-015 upd_data_entry  in  256  refill line; word w is bits [32w+31:32w].
REQ-016 upd_entry_tag_vld  in  19  {valid, tag[31:14]} for the refill.
REQ-017 l2_wt_en, l2_wt_addr[31:0], l2_wt_data[31:0]  out  write-through port used for store hits.
REQ-018 hit_cnt, miss_cnt  out  16 each  access statistics.

Function
REQ-019 Organisation: direct-mapped, 2^INDEX_W lines of 8x32-bit words, plus one tag and one valid bit per line; idx = cpu_addr[13:5], word = cpu_addr[4:2].
REQ-020 Hit condition: valid[idx] is set AND the stored tag equals cpu_addr[31:14]; evaluated combinationally in IDLE.
REQ-021 FSM states: IDLE, MISS, REPLAY.
REQ-022 IDLE, read hit: cpu_rd_data = line[idx][word] in the same cycle; cpu_stall=0; hit_cnt+1.
REQ-023 IDLE, write hit: line[idx][word] <= cpu_wr_data at the edge. On the next cycle l2_wt_en=1 for one cycle, with l2_wt_addr={2'b00,cpu_addr[31:2]} and l2_wt_data=cpu_wr_data. cpu_stall=0; hit_cnt+1.
REQ-024 IDLE, any miss: cpu_stall=1 combinationally in the same cycle. Latch cpu_addr into miss_addr, cpu_wr_data into wr_miss_data, and the request type. Go to MISS; miss_cnt+1.
REQ-025 rd_req and wr_req both high is treated as a write.
REQ-026 MISS: cpu_stall=1.
REQ-027 MISS: rd_miss or wr_miss (per the latched type) is registered high from the first MISS cycle, and stays high through the cycle in which upd_entry=1.
REQ-028 MISS: CPU inputs are ignored.
REQ-029 MISS with upd_entry=1 causes three things at that edge:
- line[miss_addr[13:5]] <= upd_data_entry.
- tag/valid <= upd_entry_tag_vld.
- Go to REPLAY.
REQ-030 rd_miss and wr_miss are 0 from the cycle after the upd_entry pulse.
REQ-031 REPLAY lasts one cycle.
REQ-032 REPLAY, read: cpu_rd_data = refilled line[word]; cpu_stall=0.
REQ-033 REPLAY, write: the line already holds the merged store data, and the miss handler performs the L2 write. No array write, no l2_wt_en; cpu_stall=0. Go to IDLE.
REQ-034 REPLAY is not counted as a hit.
REQ-035 upd_entry in IDLE or REPLAY is ignored, with no array change.
REQ-036 A refill overwrites the line unconditionally. There is no dirty state, because all stores are written through.
REQ-037 Counters wrap modulo 2^16.
REQ-038 l2_wt_en is 0 in every cycle not following a write hit.

Reset
REQ-039 With rst high at an edge, the following are reset: all valid bits=0, state=IDLE, rd_miss=wr_miss=0, miss_addr=wr_miss_data=0, l2_wt_en=0, l2_wt_addr=l2_wt_data=0, hit_cnt=miss_cnt=0.
REQ-040 Data and tag arrays are not reset.
REQ-041 During reset, cpu_stall=0 and cpu_rd_data is don't-care.
REQ-042 Reset in MISS abandons the refill. The line is not written, even if upd_entry coincides with the reset edge.

Verification
REQ-043 Cold read 0x0000_4024 after reset:
- rd_miss=1 and miss_addr=0x0000_4024.
- Deliver a line with word1=0xDEAD_BEEF and tag_vld={1,18'h1}.
- Expect the next cycle to have cpu_rd_data=0xDEAD_BEEF, cpu_stall=0, miss_cnt=1.
REQ-044 Repeat read of 0x0000_4024 -> same-cycle hit, cpu_stall=0, hit_cnt=1, no rd_miss.
REQ-045 Write hit 0x0000_4028 with data 0x1234_5678:
- Next cycle l2_wt_en=1, l2_wt_addr=0x0000_100A.
- A following read of 0x0000_4028 returns 0x1234_5678.
REQ-046 Write miss 0x0000_8000 with data 0xA5A5_A5A5:
- wr_miss=1 and wr_miss_data=0xA5A5_A5A5 until the upd_entry cycle.
- No l2_wt_en.
- The conflicting line at idx 0 is replaced, so a read of 0x0000_4000 then misses.
REQ-047 Assert rst during MISS with a simultaneous upd_entry -> state is IDLE, rd_miss=0, valid[idx]=0, and the next access to the same address misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through L1 data cache controller.
// Each line holds eight 32-bit words; misses stall the CPU until the miss handler refills the line.
module dcache_ctrl #(
  parameter int INDEX_W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_rd_req,
  input  logic         cpu_wr_req,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wr_data,
  output logic [31:0]  cpu_rd_data,
  output logic         cpu_stall,
  output logic         rd_miss,
  output logic         wr_miss,
  output logic [31:0]  miss_addr,
  output logic [31:0]  wr_miss_data,
  input  logic         upd_entry,
  input  logic [255:0] upd_data_entry,
  input  logic [18:0]  upd_entry_tag_vld,
  output logic         l2_wt_en,
  output logic [31:0]  l2_wt_addr,
  output logic [31:0]  l2_wt_data,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 27 - INDEX_W;

  typedef enum logic [1:0] {IDLE, MISS, REPLAY} state_t;

  state_t             state_q, state_d;
  logic               rd_miss_q, wr_miss_q;
  logic [31:0]        miss_addr_q, wr_miss_data_q;
  logic               l2_wt_en_q;
  logic [31:0]        l2_wt_addr_q, l2_wt_data_q;
  logic [15:0]        hit_cnt_q, miss_cnt_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_mem [0:LINES-1];

  logic               cpu_req, cache_hit;
  logic               hit_inc, hit_we, miss_start, refill_we, replay_rd;
  logic [INDEX_W-1:0] cur_idx, miss_idx, rd_idx;
  logic [TAG_W-1:0]   cur_tag;
  logic [2:0]         cur_word, rd_word;
  logic [255:0]       line_rd;
  logic               addr_lsb_unused;

  assign cpu_req         = cpu_rd_req | cpu_wr_req;
  assign cur_idx         = cpu_addr[5+INDEX_W-1:5];
  assign cur_tag         = cpu_addr[31:5+INDEX_W];
  assign cur_word        = cpu_addr[4:2];
  assign miss_idx        = miss_addr_q[5+INDEX_W-1:5];
  assign addr_lsb_unused = ^cpu_addr[1:0];
  assign cache_hit       = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

  // During REPLAY the load is served from the refilled line named by the latched address.
  assign rd_idx      = replay_rd ? miss_idx : cur_idx;
  assign rd_word     = replay_rd ? miss_addr_q[4:2] : cur_word;
  assign cpu_rd_data = line_rd[32*rd_word +: 32];

  always_comb begin
    state_d    = state_q;
    cpu_stall  = 1'b0;
    hit_inc    = 1'b0;
    hit_we     = 1'b0;
    miss_start = 1'b0;
    refill_we  = 1'b0;
    replay_rd  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req) begin
            if (cache_hit) begin
              hit_inc = 1'b1;
              hit_we  = cpu_wr_req;
            end else begin
              cpu_stall  = 1'b1;
              miss_start = 1'b1;
              state_d    = MISS;
            end
          end
        end
        MISS: begin
          cpu_stall = 1'b1;
          if (upd_entry) begin
            refill_we = 1'b1;
            state_d   = REPLAY;
          end
        end
        REPLAY: begin
          replay_rd = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      logic [31:0] word_mem [0:LINES-1];
      always_ff @(posedge clk) begin
        if (refill_we) begin
          word_mem[miss_idx] <= upd_data_entry[32*gi +: 32];
        end else if (hit_we && (cur_word == 3'(gi))) begin
          word_mem[cur_idx] <= cpu_wr_data;
        end
      end
      assign line_rd[32*gi +: 32] = word_mem[rd_idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (refill_we) begin
      tag_mem[miss_idx] <= upd_entry_tag_vld[TAG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      rd_miss_q      <= 1'b0;
      wr_miss_q      <= 1'b0;
      miss_addr_q    <= '0;
      wr_miss_data_q <= '0;
      l2_wt_en_q     <= 1'b0;
      l2_wt_addr_q   <= '0;
      l2_wt_data_q   <= '0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      l2_wt_en_q <= hit_we;
      if (hit_we) begin
        l2_wt_addr_q <= {2'b00, cpu_addr[31:2]};
        l2_wt_data_q <= cpu_wr_data;
      end
      if (hit_inc) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      // A simultaneous read and write request is handled as a store.
      if (miss_start) begin
        miss_cnt_q     <= miss_cnt_q + 16'd1;
        miss_addr_q    <= cpu_addr;
        wr_miss_data_q <= cpu_wr_data;
        rd_miss_q      <= ~cpu_wr_req;
        wr_miss_q      <= cpu_wr_req;
      end
      if (refill_we) begin
        valid_q[miss_idx] <= upd_entry_tag_vld[18];
        rd_miss_q         <= 1'b0;
        wr_miss_q         <= 1'b0;
      end
    end
  end

  assign rd_miss      = rd_miss_q;
  assign wr_miss      = wr_miss_q;
  assign miss_addr    = miss_addr_q;
  assign wr_miss_data = wr_miss_data_q;
  assign l2_wt_en     = l2_wt_en_q;
  assign l2_wt_addr   = l2_wt_addr_q;
  assign l2_wt_data   = l2_wt_data_q;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a cache/L2 reference model predicts loads, write-throughs and misses,
// while a miss-handler process services refills and independent monitors check DUT outputs.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_rd_req, cpu_wr_req;
  logic [31:0]  cpu_addr, cpu_wr_data;
  logic [31:0]  cpu_rd_data;
  logic         cpu_stall, rd_miss, wr_miss;
  logic [31:0]  miss_addr, wr_miss_data;
  logic         upd_entry;
  logic [255:0] upd_data_entry;
  logic [18:0]  upd_entry_tag_vld;
  logic         l2_wt_en;
  logic [31:0]  l2_wt_addr, l2_wt_data;
  logic [15:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_W(9)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_rd_data(cpu_rd_data), .cpu_stall(cpu_stall),
    .rd_miss(rd_miss), .wr_miss(wr_miss),
    .miss_addr(miss_addr), .wr_miss_data(wr_miss_data),
    .upd_entry(upd_entry), .upd_data_entry(upd_data_entry),
    .upd_entry_tag_vld(upd_entry_tag_vld),
    .l2_wt_en(l2_wt_en), .l2_wt_addr(l2_wt_addr), .l2_wt_data(l2_wt_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wt_t;
  typedef struct { bit is_wr; logic [31:0] addr; logic [31:0] data; } miss_t;

  int checks = 0;
  int errors = 0;

  // Reference model: backing L2 memory plus cache tag/valid state and access counters.
  logic [31:0] l2_mem [logic [29:0]];
  bit          m_valid [512];
  logic [17:0] m_tag   [512];
  logic [15:0] m_hits, m_misses;
  logic [31:0] rd_exp_q [$];
  wt_t         wt_exp_q [$];
  miss_t       miss_exp_q [$];
  bit          handler_en = 1'b1;
  int          txn_no = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (l2_mem.exists(a[31:2])) return l2_mem[a[31:2]];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Issue one CPU access, predict its outcome, hold it until the DUT accepts it.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int   idx;
    bit   hit;
    int   cyc;
    idx = int'(addr[13:5]);
    hit = m_valid[idx] && (m_tag[idx] == addr[31:14]);
    if (hit) begin
      m_hits++;
      if (wr) begin
        wt_exp_q.push_back('{{2'b00, addr[31:2]}, data});
        l2_mem[addr[31:2]] = data;
      end else begin
        rd_exp_q.push_back(mem_rd(addr));
      end
    end else begin
      m_misses++;
      miss_exp_q.push_back('{wr, addr, data});
      if (wr) l2_mem[addr[31:2]] = data;
      else    rd_exp_q.push_back(mem_rd(addr));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr[31:14];
    end
    $display("txn %0d rd=%0b wr=%0b addr=%h data=%h expect_hit=%0b", txn_no, rd, wr, addr, data, hit);
    txn_no++;
    cpu_rd_req  = rd;
    cpu_wr_req  = wr;
    cpu_addr    = addr;
    cpu_wr_data = data;
    cyc = 0;
    @(negedge clk);
    if (hit) check32("hit_no_stall", {31'b0, cpu_stall}, 32'd0);
    else     check32("miss_stall", {31'b0, cpu_stall}, 32'd1);
    while (cpu_stall) begin
      cyc++;
      if (cyc > 50) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: stall still %0b after %0d cycles, required 0", cpu_stall, cyc);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cpu_rd_req = 1'b0;
    cpu_wr_req = 1'b0;
    check32("hit_cnt", {16'b0, hit_cnt}, {16'b0, m_hits});
    check32("miss_cnt", {16'b0, miss_cnt}, {16'b0, m_misses});
  endtask

  // Monitor: completed loads and write-through beats.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cpu_rd_req && !cpu_wr_req && !cpu_stall) begin
          if (rd_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: load completed with data %h, none required", cpu_rd_data);
          end else begin
            check32("rd_data", cpu_rd_data, rd_exp_q.pop_front());
          end
        end
        if (l2_wt_en) begin
          if (wt_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL l2_wt_unexpected: l2_wt_en=1 addr %h, required 0", l2_wt_addr);
          end else begin
            wt_t w;
            w = wt_exp_q.pop_front();
            check32("l2_wt_addr", l2_wt_addr, w.addr);
            check32("l2_wt_data", l2_wt_data, w.data);
          end
        end
      end
    end
  end

  // Miss handler: checks the miss request, then refills the line from L2 (store already merged).
  initial begin
    miss_t        m;
    int           d;
    logic [255:0] line;
    logic [2:0]   wv;
    forever begin
      @(negedge clk);
      if (handler_en && !rst && (rd_miss || wr_miss)) begin
        if (miss_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL miss_unexpected: rd_miss=%0b wr_miss=%0b addr %h, none required", rd_miss, wr_miss, miss_addr);
          m = '{wr_miss, miss_addr, wr_miss_data};
        end else begin
          m = miss_exp_q.pop_front();
          check32("miss_addr", miss_addr, m.addr);
          if (m.is_wr) check32("wr_miss_data", wr_miss_data, m.data);
        end
        d = $urandom_range(0, 3);
        for (int i = 0; i <= d; i++) begin
          if (i > 0) @(negedge clk);
          check32("miss_type_hold", {30'b0, rd_miss, wr_miss}, m.is_wr ? 32'd1 : 32'd2);
          check32("miss_stall_hold", {31'b0, cpu_stall}, 32'd1);
        end
        for (int w = 0; w < 8; w++) begin
          wv = 3'(w);
          line[32*w +: 32] = mem_rd({m.addr[31:5], wv, 2'b00});
        end
        upd_data_entry    = line;
        upd_entry_tag_vld = {1'b1, m.addr[31:14]};
        upd_entry         = 1'b1;
        @(posedge clk);
        #1;
        upd_entry      = 1'b0;
        upd_data_entry = {8{$urandom}};
        @(negedge clk);
        check32("miss_clear", {30'b0, rd_miss, wr_miss}, 32'd0);
        check32("replay_no_stall", {31'b0, cpu_stall}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, dat;
    bit          rd, wr;
    int          r;
    rst = 1'b1;
    cpu_rd_req = 1'b0; cpu_wr_req = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    upd_entry = 1'b0; upd_data_entry = '0; upd_entry_tag_vld = '0;
    m_hits = '0; m_misses = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check32("rst_stall", {31'b0, cpu_stall}, 32'd0);
    check32("rst_miss", {30'b0, rd_miss, wr_miss}, 32'd0);
    check32("rst_miss_addr", miss_addr, 32'd0);
    check32("rst_wr_miss_data", wr_miss_data, 32'd0);
    check32("rst_l2_wt_en", {31'b0, l2_wt_en}, 32'd0);
    check32("rst_l2_wt_addr", l2_wt_addr, 32'd0);
    check32("rst_l2_wt_data", l2_wt_data, 32'd0);
    check32("rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    check32("rst_miss_cnt", {16'b0, miss_cnt}, 32'd0);

    // Cold read miss, repeat hit, write hit, write-miss eviction of idx 0.
    l2_mem[30'h0000_1009] = 32'hDEAD_BEEF;
    do_req(1'b1, 1'b0, 32'h0000_4024, 32'h0);
    do_req(1'b1, 1'b0, 32'h0000_4024, 32'h0);
    do_req(1'b0, 1'b1, 32'h0000_4028, 32'h1234_5678);
    do_req(1'b1, 1'b0, 32'h0000_4028, 32'h0);
    do_req(1'b0, 1'b1, 32'h0000_8000, 32'hA5A5_A5A5);
    do_req(1'b1, 1'b0, 32'h0000_4000, 32'h0);

    // Reset during MISS with a coinciding refill pulse abandons the refill.
    handler_en = 1'b0;
    cpu_rd_req = 1'b1;
    cpu_addr   = 32'h0001_4020;
    r = 0;
    @(negedge clk);
    while (!rd_miss && r < 10) begin
      r++;
      @(negedge clk);
    end
    check32("rstmiss_rd_miss", {31'b0, rd_miss}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    upd_entry = 1'b1;
    upd_data_entry = {8{32'hFFFF_0000}};
    upd_entry_tag_vld = {1'b1, 18'h5};
    @(negedge clk);
    check32("rstmiss_stall_in_rst", {31'b0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    upd_entry = 1'b0;
    cpu_rd_req = 1'b0;
    check32("rstmiss_rd_miss_clr", {31'b0, rd_miss}, 32'd0);
    check32("rstmiss_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    check32("rstmiss_miss_cnt", {16'b0, miss_cnt}, 32'd0);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_hits = '0;
    m_misses = '0;
    handler_en = 1'b1;
    do_req(1'b1, 1'b0, 32'h0001_4020, 32'h0);
    do_req(1'b1, 1'b0, 32'h0001_4024, 32'h0);

    // Random traffic over a few conflicting tags per index.
    for (int t = 0; t < 300; t++) begin
      r   = $urandom_range(0, 9);
      rd  = (r < 6) || (r == 9);
      wr  = (r >= 6);
      a   = {14'($urandom_range(1, 3)), 4'b0, 9'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      dat = $urandom;
      do_req(rd, wr, a, dat);
      if ($urandom_range(0, 5) == 0) begin
        upd_entry = 1'b1;
        upd_data_entry = {8{$urandom}};
        upd_entry_tag_vld = {1'b1, 18'($urandom)};
        @(posedge clk);
        #1;
        upd_entry = 1'b0;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check32("rd_q_drained", rd_exp_q.size(), 32'd0);
    check32("wt_q_drained", wt_exp_q.size(), 32'd0);
    check32("miss_q_drained", miss_exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
